// File: rtl/mau_pkg.sv
// Shared types for the load/store unit.
//   state_e   : transaction FSM states
//   SZ_*      : access size encodings (2'b11 is handled as a word)
//   bus_cmd_t : registered bus command plus the load-extraction context
//   lane_be / lane_wdata : byte-enable and store-replication helpers
package mau_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  a;     // byte offset, kept for load extraction
    logic [1:0]  size;
    logic        uns;
  } bus_cmd_t;

  // Halfwords only look at a[1]; an odd halfword address still lands on its
  // aligned lane pair.
  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: return 4'b0001 << a;
      SZ_HALF: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      SZ_BYTE: return {4{wd[7:0]}};
      SZ_HALF: return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// load_align: combinational load-data aligner.
//   bus_rdata : raw 32-bit word from the bus
//   a         : byte offset of the access
//   size      : SZ_BYTE / SZ_HALF / word
//   uns       : 1 = zero-extend, 0 = sign-extend
//   rdata_ext : aligned, extended result
module load_align
  import mau_pkg::*;
(
  input  logic [31:0] bus_rdata,
  input  logic [1:0]  a,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] rdata_ext
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (a)
      2'd0:    b = bus_rdata[7:0];
      2'd1:    b = bus_rdata[15:8];
      2'd2:    b = bus_rdata[23:16];
      default: b = bus_rdata[31:24];
    endcase
    h = a[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size)
      SZ_BYTE: rdata_ext = {{24{~uns & b[7]}}, b};
      SZ_HALF: rdata_ext = {{16{~uns & h[15]}}, h};
      default: rdata_ext = bus_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the ALU result and a handshaked
// data-memory bus. One bus transaction per load/store, stall held until done.
//   clk, reset          : clock, async active-high reset
//   memread/memwrite    : request (both high = write)
//   size, uns           : access size, zero-extend loads
//   addr, wdata         : byte address, store data
//   readdata            : aligned/extended load result (held between loads)
//   stall               : freeze PC/writeback
//   misalign            : one-cycle pulse on a rejected misaligned request
//   bus_*               : registered request side, bus_ack/bus_rdata response
// Optional: MAU_ALIGN_CHECK_EN rejects misaligned halfword/word requests and
// pulses misalign; otherwise misaligned requests use the aligned lanes.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [1:0]    size,
  input  logic          uns,
  input  logic [DW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] readdata,
  output logic          stall,
  output logic          misalign,
  output logic          bus_req,
  output logic          bus_we,
  output logic [DW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata
);

  state_e        state_q, state_d;
  bus_cmd_t      cmd_q, cmd_d;
  logic          bus_req_q, bus_req_d;
  logic [DW-1:0] readdata_q, readdata_d;
  logic          misalign_q, misalign_d;
  logic [DW-1:0] load_val;
  logic          req_any, mis, req_ok;

  assign req_any = memread | memwrite;

`ifdef MAU_ALIGN_CHECK_EN
  // size[1] covers both word encodings
  assign mis = (size == SZ_HALF && addr[0]) || (size[1] && addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  assign req_ok = req_any & ~mis;

  load_align u_load_align (
    .bus_rdata (bus_rdata),
    .a         (cmd_q.a),
    .size      (cmd_q.size),
    .uns       (cmd_q.uns),
    .rdata_ext (load_val)
  );

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    bus_req_d  = bus_req_q;
    readdata_d = readdata_q;
    misalign_d = 1'b0;
    case (state_q)
      IDLE: begin
        misalign_d = req_any & mis;
        if (req_ok) begin
          cmd_d.we    = memwrite;
          cmd_d.addr  = {addr[DW-1:2], 2'b00};
          cmd_d.be    = lane_be(size, addr[1:0]);
          cmd_d.wdata = lane_wdata(size, wdata);
          cmd_d.a     = addr[1:0];
          cmd_d.size  = size;
          cmd_d.uns   = uns;
          bus_req_d   = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = DONE;
          if (!cmd_q.we) readdata_d = load_val;
        end
      end
      // The request still on the inputs belongs to the finishing instruction.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      bus_req_q  <= 1'b0;
      readdata_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      bus_req_q  <= bus_req_d;
      readdata_q <= readdata_d;
      misalign_q <= misalign_d;
    end
  end

  assign stall     = ~reset & (((state_q == IDLE) & req_ok) | (state_q == REQ));
  assign readdata  = readdata_q;
  assign misalign  = misalign_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = cmd_q.we;
  assign bus_addr  = cmd_q.addr;
  assign bus_be    = cmd_q.be;
  assign bus_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: acts as controller and bus slave. Expected
// transactions are queued at stimulus time; the slave queues what it sees on
// each ack, and each scenario pops and compares both.
module tb_mem_access_unit;
  import mau_pkg::*;

  logic        clk = 0, reset;
  logic        memread, memwrite, uns, bus_ack;
  logic [1:0]  size;
  logic [31:0] addr, wdata, bus_rdata;
  logic [31:0] readdata, bus_addr, bus_wdata;
  logic        stall, misalign, bus_req, bus_we;
  logic [3:0]  bus_be;

  int checks = 0, errors = 0;

  typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; logic [31:0] rdata; } exp_t;
  typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; } obs_t;
  typedef struct { logic [1:0] sz; logic un; logic [31:0] ad; logic [31:0] bus; int waits;
                   logic [31:0] e_addr; logic [3:0] e_be; logic [31:0] e_rd; } ld_t;
  exp_t exp_q[$];
  obs_t obs_q[$];

  always #5 clk = ~clk;

  mem_access_unit #(.DW(32)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite), .size(size),
    .uns(uns), .addr(addr), .wdata(wdata), .readdata(readdata), .stall(stall),
    .misalign(misalign), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  // Entered 1 time unit after an edge; leaves 1 unit after the edge that
  // follows the first non-stalled cycle. Samples at 2 units past the edge.
  task automatic run_instr(input logic rd, input logic wr, input logic [1:0] sz, input logic un,
                           input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rdat,
                           input int waits, output int stall_cyc, output int starts,
                           output logic done_req, output logic tmo);
    int w;
    logic prev;
    memread = rd; memwrite = wr; size = sz; uns = un; addr = ad; wdata = wd;
    w = waits; stall_cyc = 0; starts = 0; tmo = 1; prev = 0; done_req = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus_req && !prev) starts++;
      prev = bus_req;
      if (stall) stall_cyc++;
      bus_ack = 0;
      if (bus_req) begin
        if (w == 0) begin
          bus_ack = 1; bus_rdata = rdat;
          obs_q.push_back('{bus_addr, bus_be, bus_we, bus_wdata});
        end else w--;
      end
      if (!stall) begin
        done_req = bus_req; tmo = 0;
        @(posedge clk); #1; bus_ack = 0;
        break;
      end
      @(posedge clk); #1;
    end
    bus_ack = 0;
  endtask

  task automatic idle();
    memread = 0; memwrite = 0; size = 0; uns = 0; addr = 0; wdata = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL rst_readdata: got %h exp 0", readdata); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_bus_req: got %b exp 0", bus_req); end
    checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL rst_bus_we: got %b exp 0", bus_we); end
    checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL rst_bus_addr: got %h exp 0", bus_addr); end
    checks++; if (bus_be !== 4'h0) begin errors++; $display("FAIL rst_bus_be: got %b exp 0", bus_be); end
    checks++; if (bus_wdata !== 32'h0) begin errors++; $display("FAIL rst_bus_wdata: got %h exp 0", bus_wdata); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b exp 0", misalign); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b exp 0", stall); end
  endtask

  task automatic test_word_store();
    int sc, st; logic dr, tmo; logic [31:0] rd0; exp_t e; obs_t o;
    rd0 = readdata;
    exp_q.push_back('{32'h104, 4'b1111, 1'b1, 32'hDEADBEEF, rd0});
    run_instr(0, 1, SZ_WORD, 0, 32'h104, 32'hDEADBEEF, 32'h0, 2, sc, st, dr, tmo);
    idle();
    e = exp_q.pop_front();
    checks++; if (tmo) begin errors++; $display("FAIL ws_timeout: stall never dropped"); end
    checks++; if (sc != 4) begin errors++; $display("FAIL ws_stall_cycles: got %0d exp 4", sc); end
    checks++; if (st != 1) begin errors++; $display("FAIL ws_txn_count: got %0d exp 1", st); end
    checks++; if (dr !== 1'b0) begin errors++; $display("FAIL ws_req_in_done: got %b exp 0", dr); end
    checks++; if (readdata !== e.rdata) begin errors++; $display("FAIL ws_readdata: got %h exp %h", readdata, e.rdata); end
    checks++;
    if (obs_q.size() == 0) begin errors++; $display("FAIL ws_txn: got none exp one"); end
    else begin
      o = obs_q.pop_front();
      if (o.addr !== e.addr || o.be !== e.be || o.we !== e.we || o.wdata !== e.wdata) begin
        errors++;
        $display("FAIL ws_txn: got addr %h be %b we %b wd %h exp addr %h be %b we %b wd %h",
                 o.addr, o.be, o.we, o.wdata, e.addr, e.be, e.we, e.wdata);
      end
    end
  endtask

  task automatic test_half_store();
    int sc, st; logic dr, tmo; exp_t e; obs_t o;
    exp_q.push_back('{32'h0, 4'b1100, 1'b1, 32'h12341234, 32'h0});
    run_instr(1, 1, SZ_HALF, 0, 32'h002, 32'h00001234, 32'h0, 0, sc, st, dr, tmo);
    idle();
    e = exp_q.pop_front();
    checks++; if (tmo || sc != 2) begin errors++; $display("FAIL hs_stall_cycles: got %0d exp 2", sc); end
    checks++;
    if (obs_q.size() == 0) begin errors++; $display("FAIL hs_txn: got none exp one"); end
    else begin
      o = obs_q.pop_front();
      if (o.addr !== e.addr || o.be !== e.be || o.we !== e.we || o.wdata !== e.wdata) begin
        errors++;
        $display("FAIL hs_txn: got addr %h be %b we %b wd %h exp addr %h be %b we %b wd %h",
                 o.addr, o.be, o.we, o.wdata, e.addr, e.be, e.we, e.wdata);
      end
    end
  endtask

  // b2b=1 chains instructions with no idle cycle between them.
  task automatic test_loads(input logic b2b);
    ld_t t[7];
    int sc, st; logic dr, tmo; exp_t e; obs_t o;
    t[0] = '{SZ_BYTE, 1'b0, 32'h203, 32'h80000000, 0, 32'h200, 4'b1000, 32'hFFFFFF80};
    t[1] = '{SZ_BYTE, 1'b1, 32'h203, 32'h80000000, 0, 32'h200, 4'b1000, 32'h00000080};
    t[2] = '{SZ_HALF, 1'b0, 32'h002, 32'h80017FFF, 1, 32'h000, 4'b1100, 32'hFFFF8001};
    t[3] = '{SZ_HALF, 1'b1, 32'h000, 32'h1234F00D, 0, 32'h000, 4'b0011, 32'h0000F00D};
    t[4] = '{SZ_BYTE, 1'b1, 32'h405, 32'h0000AB00, 2, 32'h404, 4'b0010, 32'h000000AB};
    t[5] = '{SZ_HALF, 1'b0, 32'h406, 32'h90000000, 0, 32'h404, 4'b1100, 32'hFFFF9000};
    t[6] = '{2'b11,   1'b0, 32'h408, 32'hCAFEF00D, 0, 32'h408, 4'b1111, 32'hCAFEF00D};
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back('{t[i].e_addr, t[i].e_be, 1'b0, 32'h0, t[i].e_rd});
      run_instr(1, 0, t[i].sz, t[i].un, t[i].ad, 32'h0, t[i].bus, t[i].waits, sc, st, dr, tmo);
      if (!b2b) idle();
      e = exp_q.pop_front();
      checks++; if (tmo || sc != 2 + t[i].waits) begin errors++; $display("FAIL ld%0d_b2b%0b_stall: got %0d exp %0d", i, b2b, sc, 2 + t[i].waits); end
      checks++; if (st != 1 || dr !== 1'b0) begin errors++; $display("FAIL ld%0d_b2b%0b_issue: got %0d starts done_req %b exp 1 starts done_req 0", i, b2b, st, dr); end
      checks++; if (readdata !== e.rdata) begin errors++; $display("FAIL ld%0d_b2b%0b_readdata: got %h exp %h", i, b2b, readdata, e.rdata); end
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL ld%0d_b2b%0b_txn: got none exp one", i, b2b); end
      else begin
        o = obs_q.pop_front();
        if (o.addr !== e.addr || o.be !== e.be || o.we !== 1'b0) begin
          errors++;
          $display("FAIL ld%0d_b2b%0b_txn: got addr %h be %b we %b exp addr %h be %b we 0", i, b2b, o.addr, o.be, o.we, e.addr, e.be);
        end
      end
    end
    if (b2b) idle();
  endtask

  task automatic test_misalign();
    logic [31:0] rd0;
`ifdef MAU_ALIGN_CHECK_EN
    rd0 = readdata;
    memread = 1; size = SZ_WORD; addr = 32'h101; uns = 0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b exp 0", stall); end
    @(posedge clk); #1;
    memread = 0;
    #1;
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b exp 1", misalign); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL mis_bus_req: got %b exp 0", bus_req); end
    @(posedge clk); #2;
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_pulse_end: got %b exp 0", misalign); end
    checks++; if (bus_req !== 1'b0 || readdata !== rd0) begin errors++; $display("FAIL mis_no_access: got req %b rd %h exp req 0 rd %h", bus_req, readdata, rd0); end
    @(posedge clk); #1;
    idle();
`else
    int sc, st; logic dr, tmo; exp_t e; obs_t o;
    exp_q.push_back('{32'h100, 4'b1111, 1'b0, 32'h0, 32'h5566AA77});
    run_instr(1, 0, SZ_WORD, 0, 32'h101, 32'h0, 32'h5566AA77, 0, sc, st, dr, tmo);
    rd0 = readdata;
    idle();
    e = exp_q.pop_front();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_tied: got %b exp 0", misalign); end
    checks++; if (tmo || rd0 !== e.rdata) begin errors++; $display("FAIL mis_readdata: got %h exp %h", rd0, e.rdata); end
    checks++;
    if (obs_q.size() == 0) begin errors++; $display("FAIL mis_txn: got none exp one"); end
    else begin
      o = obs_q.pop_front();
      if (o.addr !== e.addr || o.be !== e.be) begin errors++; $display("FAIL mis_txn: got addr %h be %b exp addr %h be %b", o.addr, o.be, e.addr, e.be); end
    end
`endif
  endtask

  task automatic test_reset_mid();
    int sc, st; logic dr, tmo; obs_t o;
    memread = 1; size = SZ_WORD; addr = 32'h300; uns = 0;
    @(posedge clk); #1;
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rm_in_req: got %b exp 1", bus_req); end
    reset = 1; memread = 0;
    #1;
    checks++; if (bus_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rm_drop: got req %b stall %b exp 0 0", bus_req, stall); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rm_state: got %0d exp %0d", dut.state_q, IDLE); end
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    run_instr(1, 0, SZ_WORD, 0, 32'h304, 32'h0, 32'h11223344, 1, sc, st, dr, tmo);
    idle();
    checks++; if (tmo || sc != 3 || readdata !== 32'h11223344) begin errors++; $display("FAIL rm_after: got stall %0d rd %h exp stall 3 rd 11223344", sc, readdata); end
    checks++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL rm_txn: got %0d txns exp 1", obs_q.size()); end
    else begin
      o = obs_q.pop_front();
      if (o.addr !== 32'h304) begin errors++; $display("FAIL rm_txn: got addr %h exp 00000304", o.addr); end
    end
  endtask

  initial begin
    reset = 1; memread = 0; memwrite = 0; size = 0; uns = 0; addr = 0; wdata = 0;
    bus_ack = 0; bus_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 0;
    @(posedge clk); #1;
    test_word_store();
    test_loads(1'b0);
    test_half_store();
    test_misalign();
    test_reset_mid();
    test_loads(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
